// File: rtl/axi_sd_lite_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between NUM_REQ register requesters.
// Optional `AXI_SD_ARB_LOCK_EN adds req_lock so a requester can keep priority across an RMW sequence.
module axi_sd_lite_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
`ifdef AXI_SD_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]             req_lock,
`endif
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_err,
    output logic [ADDR_WIDTH-1:0]          M_AXI_AWADDR,
    output logic [2:0]                     M_AXI_AWPROT,
    output logic                           M_AXI_AWVALID,
    input  logic                           M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]          M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]        M_AXI_WSTRB,
    output logic                           M_AXI_WVALID,
    input  logic                           M_AXI_WREADY,
    input  logic [1:0]                     M_AXI_BRESP,
    input  logic                           M_AXI_BVALID,
    output logic                           M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]          M_AXI_ARADDR,
    output logic [2:0]                     M_AXI_ARPROT,
    output logic                           M_AXI_ARVALID,
    input  logic                           M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]          M_AXI_RDATA,
    input  logic [1:0]                     M_AXI_RRESP,
    input  logic                           M_AXI_RVALID,
    output logic                           M_AXI_RREADY
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP
    } state_t;

    state_t              state, state_nxt;
    logic [PTR_W-1:0]    rr_ptr, gnt_idx, sel_idx;
    logic [PTR_W:0]      cand_sum;
    logic                sel_found, grant;
    logic                aw_done, w_done;
    logic                aw_hs, w_hs, ar_hs;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [DATA_WIDTH-1:0] op_wdata, op_rdata;
    logic [STRB_W-1:0]     op_wstrb;
    logic                  op_err;

    // First requesting index at or after the round-robin pointer, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_sum  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (cand_sum >= NUM_REQ_W)
                cand_sum = cand_sum - NUM_REQ_W;
            if (!sel_found && req_valid[cand_sum[PTR_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand_sum[PTR_W-1:0];
            end
        end
    end

    assign grant = (state == IDLE) && sel_found;
    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;

    always_comb begin
        state_nxt     = state;
        req_ready     = '0;
        rsp_valid     = '0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    req_ready[sel_idx] = ARESETN;
                    state_nxt = req_we[sel_idx] ? WR_AW_W : RD_AR;
                end
            end
            WR_AW_W: begin
                M_AXI_AWVALID = !aw_done;
                M_AXI_WVALID  = !w_done;
                if ((aw_done || aw_hs) && (w_done || w_hs))
                    state_nxt = WR_B;
            end
            WR_B: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID)
                    state_nxt = RESP;
            end
            RD_AR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY)
                    state_nxt = RD_R;
            end
            RD_R: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID)
                    state_nxt = RESP;
            end
            RESP: begin
                rsp_valid[gnt_idx] = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Payload is forced to zero whenever its valid is low so reset leaves every output at 0.
    assign M_AXI_AWADDR = M_AXI_AWVALID ? op_addr  : '0;
    assign M_AXI_WDATA  = M_AXI_WVALID  ? op_wdata : '0;
    assign M_AXI_WSTRB  = M_AXI_WVALID  ? op_wstrb : '0;
    assign M_AXI_ARADDR = M_AXI_ARVALID ? op_addr  : '0;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign rsp_rdata    = (state == RESP) ? op_rdata : '0;
    assign rsp_err      = (state == RESP) && op_err;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gnt_idx <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                gnt_idx <= sel_idx;
                rr_ptr  <= (sel_idx == LAST_IDX) ? '0 : sel_idx + PTR_W'(1);
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (state == WR_AW_W) begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
`ifdef AXI_SD_ARB_LOCK_EN
            if (state == RESP && req_lock[gnt_idx])
                rr_ptr <= gnt_idx;
`endif
        end
    end

    // Datapath captures need no reset: every consumer is qualified by FSM state.
    always_ff @(posedge ACLK) begin
        if (grant) begin
            op_addr  <= req_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
            op_wdata <= req_wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
            op_wstrb <= req_wstrb[sel_idx*STRB_W +: STRB_W];
        end
        if (state == WR_B && M_AXI_BVALID) begin
            op_rdata <= '0;
            op_err   <= |M_AXI_BRESP;
        end
        if (state == RD_R && M_AXI_RVALID) begin
            op_rdata <= M_AXI_RDATA;
            op_err   <= |M_AXI_RRESP;
        end
    end

endmodule

// File: tb/tb_axi_sd_lite_arbiter.sv
// Directed bench for axi_sd_lite_arbiter with a small AXI4-Lite register slave (4 x 32-bit regs).
module tb_axi_sd_lite_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
`ifdef AXI_SD_ARB_LOCK_EN
    logic [1:0]  req_lock;
`endif
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    int n_checks = 0;
    int n_fail   = 0;

    axi_sd_lite_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
`ifdef AXI_SD_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    // Slave model: AWREADY after aw_delay cycles of AWVALID, WREADY/ARREADY immediate,
    // read data rd_lat cycles late, SLVERR on reads of 0x8. Reset by the same ARESETN.
    int          aw_delay = 0;
    int          rd_lat   = 0;
    int          aw_cnt, r_cnt;
    logic [31:0] mem [4];
    logic        aw_got, w_got, bvalid, rvalid, r_pend;
    logic [3:0]  awaddr_q, wstrb_q, wr_addr, wr_strb;
    logic [31:0] wdata_q, wr_data, rdata_s;
    logic [1:0]  rresp_s;
    logic        aw_hs, w_hs, ar_hs;

    assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_delay);
    assign M_AXI_WREADY  = M_AXI_WVALID;
    assign M_AXI_ARREADY = M_AXI_ARVALID;
    assign M_AXI_BVALID  = bvalid;
    assign M_AXI_BRESP   = 2'b00;
    assign M_AXI_RVALID  = rvalid;
    assign M_AXI_RDATA   = rdata_s;
    assign M_AXI_RRESP   = rresp_s;
    assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs    = M_AXI_WVALID && M_AXI_WREADY;
    assign ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
    assign wr_addr = aw_hs ? M_AXI_AWADDR : awaddr_q;
    assign wr_data = w_hs ? M_AXI_WDATA : wdata_q;
    assign wr_strb = w_hs ? M_AXI_WSTRB : wstrb_q;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 4; i++) mem[i] <= 32'h1000_0000 + i;
            aw_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0; r_pend <= 1'b0;
            awaddr_q <= '0; wstrb_q <= '0; wdata_q <= '0; rdata_s <= '0; rresp_s <= '0;
        end else begin
            aw_cnt <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
            if (aw_hs) awaddr_q <= M_AXI_AWADDR;
            if (w_hs) begin
                wdata_q <= M_AXI_WDATA;
                wstrb_q <= M_AXI_WSTRB;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) bvalid <= 1'b0;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) mem[wr_addr[3:2]][8*b +: 8] <= wr_data[8*b +: 8];
                bvalid <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                aw_got <= aw_got || aw_hs;
                w_got  <= w_got || w_hs;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) rvalid <= 1'b0;
            if (ar_hs) begin
                rdata_s <= mem[M_AXI_ARADDR[3:2]];
                rresp_s <= (M_AXI_ARADDR == 4'h8) ? 2'b10 : 2'b00;
                if (rd_lat == 0) rvalid <= 1'b1;
                else begin
                    r_pend <= 1'b1;
                    r_cnt  <= rd_lat - 1;
                end
            end else if (r_pend) begin
                if (r_cnt == 0) begin
                    rvalid <= 1'b1;
                    r_pend <= 1'b0;
                end else r_cnt <= r_cnt - 1;
            end
        end
    end

    // Monotonic activity counters; tests take deltas against a snapshot.
    int grants[$];
    int aw_cyc = 0, w_cyc = 0, b_cnt = 0, rsp_cnt = 0, rsp0_cnt = 0, rsp1_cnt = 0;

    always @(posedge ACLK) begin
        if (ARESETN) begin
            if (|req_ready) grants.push_back(req_ready[1] ? 1 : 0);
            if (M_AXI_AWVALID) aw_cyc <= aw_cyc + 1;
            if (M_AXI_WVALID)  w_cyc  <= w_cyc + 1;
            if (M_AXI_BVALID && M_AXI_BREADY) b_cnt <= b_cnt + 1;
            if (|rsp_valid) rsp_cnt <= rsp_cnt + 1;
            if (rsp_valid[0]) rsp0_cnt <= rsp0_cnt + 1;
            if (rsp_valid[1]) rsp1_cnt <= rsp1_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge ACLK);
        ARESETN   = 1'b0;
        req_valid = '0;
`ifdef AXI_SD_ARB_LOCK_EN
        req_lock  = '0;
`endif
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    task automatic do_op(input int r, input logic we, input logic [3:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws, input string tag,
                         output logic [31:0] rd, output logic er, output logic [1:0] rv);
        int cyc;
        @(negedge ACLK);
        req_we[r] = we;
        req_addr[r*4 +: 4]   = addr;
        req_wdata[r*32 +: 32] = wd;
        req_wstrb[r*4 +: 4]  = ws;
        req_valid[r] = 1'b1;
        #1;
        cyc = 0;
        while (!req_ready[r] && cyc < 100) begin
            @(negedge ACLK); #1; cyc++;
        end
        check({tag, "_grant_timeout"}, 64'(cyc >= 100), 0);
        @(negedge ACLK);
        req_valid[r] = 1'b0;
        cyc = 0;
        while (!rsp_valid[r] && cyc < 100) begin
            @(negedge ACLK); cyc++;
        end
        check({tag, "_rsp_timeout"}, 64'(cyc >= 100), 0);
        rd = rsp_rdata;
        er = rsp_err;
        rv = rsp_valid;
    endtask

    // Both requesters valid continuously; both valids drop in the cycle of the n-th response.
    task automatic run_pair(input logic we, input int n_ops, input string tag);
        int seen, cyc, base_g, base_r;
`ifdef AXI_SD_ARB_LOCK_EN
        int g0;
`endif
        base_g = grants.size();
        base_r = rsp_cnt;
        @(negedge ACLK);
        req_we    = {we, we};
        req_addr  = {4'h4, 4'h0};
        req_wdata = {32'h2222_0002, 32'h1111_0001};
        req_wstrb = 8'hFF;
`ifdef AXI_SD_ARB_LOCK_EN
        req_lock  = {1'b0, we};
`endif
        req_valid = 2'b11;
        seen = 0;
        cyc  = 0;
        while (seen < n_ops && cyc < 200) begin
            @(negedge ACLK); cyc++;
            if (|rsp_valid) seen++;
`ifdef AXI_SD_ARB_LOCK_EN
            g0 = 0;
            for (int i = base_g; i < grants.size(); i++) if (grants[i] == 0) g0++;
            if (g0 >= 3) req_lock = '0;
`endif
            if (seen >= n_ops) req_valid = '0;
        end
        req_valid = '0;
        check({tag, "_timeout"}, 64'(seen < n_ops), 0);
        repeat (3) @(negedge ACLK);
        check({tag, "_ngrants"}, 64'(grants.size() - base_g), 64'(n_ops));
        check({tag, "_nrsp"}, 64'(rsp_cnt - base_r), 64'(n_ops));
    endtask

    logic [31:0] rd;
    logic        er;
    logic [1:0]  rv;
    int          base_aw, base_w, base_b, base_r, base_g, cyc;
    int          exp_order [4];

    initial begin
        ARESETN   = 1'b0;
        req_valid = 2'b11;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
`ifdef AXI_SD_ARB_LOCK_EN
        req_lock  = '0;
`endif
        #12;
        check("rst_handshakes", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        check("rst_payload", {M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WDATA}, 0);
        req_valid = '0;
        @(negedge ACLK);
        ARESETN = 1'b1;

        // Test 1: zero-wait write with cycle-exact latency, then read back.
        @(negedge ACLK);
        req_we = 2'b01; req_addr[3:0] = 4'h4; req_wdata[31:0] = 32'hA5A5_0001; req_wstrb[3:0] = 4'hF;
        req_valid = 2'b01;
        #1;
        check("t1_ready_T", req_ready, 2'b01);
        @(negedge ACLK);
        req_valid = '0;
        check("t1_aw_w_valid_T1", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
        check("t1_req_ready_T1", req_ready, 0);
        check("t1_awaddr", M_AXI_AWADDR, 4'h4);
        check("t1_wdata", M_AXI_WDATA, 32'hA5A5_0001);
        check("t1_wstrb", M_AXI_WSTRB, 4'hF);
        @(negedge ACLK);
        check("t1_bready_T2", M_AXI_BREADY, 1);
        check("t1_rsp_T2", rsp_valid, 0);
        @(negedge ACLK);
        check("t1_rsp_T3", rsp_valid, 2'b01);
        check("t1_wr_err", rsp_err, 0);
        check("t1_wr_rdata", rsp_rdata, 0);
        @(negedge ACLK);
        check("t1_rsp_T4", rsp_valid, 0);
        do_op(0, 1'b0, 4'h4, 32'h0, 4'h0, "t1_rd", rd, er, rv);
        check("t1_rdata", rd, 32'hA5A5_0001);
        check("t1_rd_err", er, 0);

        // Test 2: continuous requests from reset alternate 0,1,0,1.
        apply_reset();
        base_g = grants.size();
        base_r = rsp0_cnt;
        cyc    = rsp1_cnt;
        run_pair(1'b0, 4, "t2");
        exp_order = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++)
            if (base_g + i < grants.size())
                check($sformatf("t2_grant%0d", i), 64'(grants[base_g + i]), 64'(exp_order[i]));
        check("t2_rsp_req0", 64'(rsp0_cnt - base_r), 2);
        check("t2_rsp_req1", 64'(rsp1_cnt - cyc), 2);

        // Test 3: AWREADY three cycles late, partial strobes.
        aw_delay = 3;
        base_aw = aw_cyc; base_w = w_cyc; base_b = b_cnt;
        do_op(0, 1'b1, 4'hC, 32'hDEAD_BEEF, 4'h3, "t3", rd, er, rv);
        repeat (2) @(negedge ACLK);
        check("t3_awvalid_cycles", 64'(aw_cyc - base_aw), 4);
        check("t3_wvalid_cycles", 64'(w_cyc - base_w), 1);
        check("t3_b_count", 64'(b_cnt - base_b), 1);
        check("t3_err", er, 0);
        aw_delay = 0;
        do_op(1, 1'b0, 4'hC, 32'h0, 4'h0, "t3_rd", rd, er, rv);
        check("t3_rdata_strobed", rd, 32'h1000_BEEF);

        // Test 4: slave error on read of 0x8.
        do_op(1, 1'b0, 4'h8, 32'h0, 4'h0, "t4", rd, er, rv);
        check("t4_err", er, 1);
        check("t4_rsp_onehot", rv, 2'b10);
        check("t4_rdata", rd, 32'h1000_0002);
        @(negedge ACLK);
        check("t4_err_pulse_end", {rsp_valid, rsp_err}, 0);

        // Test 5: reset in the middle of a read, pointer back to 0 afterwards.
        apply_reset();
        rd_lat = 10;
        @(negedge ACLK);
        req_we = 2'b00; req_addr = {4'h4, 4'h0};
        req_valid = 2'b01;
        cyc = 0;
        while (!M_AXI_RREADY && cyc < 50) begin
            @(negedge ACLK); cyc++;
            req_valid = 2'b11;
        end
        check("t5_in_rd_r", {M_AXI_RREADY, M_AXI_ARVALID}, 2'b10);
        base_r = rsp_cnt;
        ARESETN = 1'b0;
        #1;
        check("t5_rst_rready", M_AXI_RREADY, 0);
        check("t5_rst_arvalid", M_AXI_ARVALID, 0);
        check("t5_rst_rsp_valid", rsp_valid, 0);
        check("t5_rst_req_ready", req_ready, 0);
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        check("t5_regrant_req0", req_ready, 2'b01);
        check("t5_no_lost_rsp", 64'(rsp_cnt - base_r), 0);
        @(negedge ACLK);
        req_valid = '0;
        cyc = 0;
        while (!rsp_valid[0] && cyc < 50) begin
            @(negedge ACLK); cyc++;
        end
        check("t5_rsp_req0", rsp_valid, 2'b01);
        check("t5_rdata", rsp_rdata, 32'h1000_0000);
        rd_lat = 0;

        // Test 6: three writes from req0 with req1 pending (lock keeps req0 when enabled).
        apply_reset();
        base_g = grants.size();
        run_pair(1'b1, 4, "t6");
`ifdef AXI_SD_ARB_LOCK_EN
        exp_order = '{0, 0, 0, 1};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        for (int i = 0; i < 4; i++)
            if (base_g + i < grants.size())
                check($sformatf("t6_grant%0d", i), 64'(grants[base_g + i]), 64'(exp_order[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
